// File: rtl/rx_word_align_ctrl.sv
// rx_word_align_ctrl: reads serial bits from an async FIFO, finds K28.5 commas and locks the
// 10-bit boundary (HUNT/VERIFY/SYNC). Optional word timeout: define RX_ALIGN_TIMEOUT_EN.
module rx_word_align_ctrl #(
  parameter int unsigned VERIFY_CNT    = 3,
  parameter int unsigned LOSS_CNT      = 2,
  parameter int unsigned TIMEOUT_WORDS = 1024
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_En,
  input  logic       i_Empty,
  output logic       o_R_en,
  input  logic       i_Bit,
  output logic [9:0] o_Word,
  output logic       o_Word_Valid,
  output logic       o_Is_Comma,
  output logic       o_Sync,
  output logic       o_Realign,
  output logic [1:0] o_State
);
  // state  | meaning
  // HUNT   | no boundary; every bit position is searched for a comma
  // VERIFY | candidate boundary; counting aligned commas
  // SYNC   | boundary locked; counting consecutive misaligned commas
  typedef enum logic [1:0] {HUNT = 2'b00, VERIFY = 2'b01, SYNC = 2'b10} state_t;

  localparam logic [9:0] COMMA_NEG  = 10'b0011111010;
  localparam logic [9:0] COMMA_POS  = 10'b1100000101;
  localparam logic [3:0] VERIFY_LIM = 4'(VERIFY_CNT);
  localparam logic [3:0] LOSS_LIM   = 4'(LOSS_CNT);
  // A single required comma makes the locking comma itself sufficient for SYNC.
  localparam state_t     LOCK_STATE = (VERIFY_CNT <= 1) ? SYNC : VERIFY;

  state_t     r_state;
  logic       r_rd_pend;
  logic [9:0] r_win;
  logic [3:0] r_fill;
  logic [3:0] r_bit_pos;
  logic [3:0] r_good;
  logic [3:0] r_miss;
  logic [9:0] r_word;
  logic       r_word_valid;
  logic       r_is_comma;
  logic       r_sync;
  logic       r_realign;

  logic [9:0] w_win_nxt;
  logic       w_comma;
  logic       w_boundary;
  logic       w_realign;
  logic       w_to_hit;

  assign o_R_en     = i_En & ~i_Empty & ~i_Rst;
  assign w_win_nxt  = {r_win[8:0], i_Bit};
  assign w_comma    = r_rd_pend & (r_fill >= 4'd9) &
                      ((w_win_nxt == COMMA_NEG) || (w_win_nxt == COMMA_POS));
  assign w_boundary = r_rd_pend & (r_bit_pos == 4'd9);
  assign w_realign  = w_comma & ((r_state == HUNT) | ((r_state == VERIFY) & ~w_boundary));

`ifdef RX_ALIGN_TIMEOUT_EN
  localparam int unsigned   TW          = $clog2(TIMEOUT_WORDS) + 1;
  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_WORDS);

  logic [TW-1:0] r_wcnt;
  logic          w_wcnt_clr;
  logic          w_wcnt_inc;

  assign w_wcnt_clr = w_comma & ((r_state != SYNC) | w_boundary);
  assign w_wcnt_inc = w_boundary & ~w_comma & (r_state != HUNT);
  assign w_to_hit   = w_wcnt_inc & ((r_wcnt + TW'(1)) == TIMEOUT_LIM);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_wcnt <= '0;
    end else if (w_to_hit || w_wcnt_clr) begin
      r_wcnt <= '0;
    end else if (w_wcnt_inc) begin
      r_wcnt <= r_wcnt + TW'(1);
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state      <= HUNT;
      r_rd_pend    <= 1'b0;
      r_win        <= '0;
      r_fill       <= '0;
      r_bit_pos    <= '0;
      r_good       <= '0;
      r_miss       <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_is_comma   <= 1'b0;
      r_sync       <= 1'b0;
      r_realign    <= 1'b0;
    end else begin
      r_rd_pend    <= o_R_en;
      r_word_valid <= 1'b0;
      r_is_comma   <= 1'b0;
      r_realign    <= 1'b0;
      if (r_rd_pend) begin
        r_win     <= w_win_nxt;
        r_fill    <= (r_fill == 4'd10) ? r_fill : r_fill + 4'd1;
        r_bit_pos <= (r_bit_pos == 4'd9) ? 4'd0 : r_bit_pos + 4'd1;
        if (w_realign) begin
          // The comma just completed ends a word, so the next bit starts a new one.
          r_bit_pos    <= 4'd0;
          r_good       <= 4'd1;
          r_miss       <= 4'd0;
          r_realign    <= 1'b1;
          r_word       <= w_win_nxt;
          r_word_valid <= 1'b1;
          r_is_comma   <= 1'b1;
          r_state      <= LOCK_STATE;
          r_sync       <= (LOCK_STATE == SYNC);
        end else if (w_boundary && (r_state != HUNT)) begin
          r_word       <= w_win_nxt;
          r_word_valid <= 1'b1;
          r_is_comma   <= w_comma;
          if (w_comma) begin
            if (r_state == VERIFY) begin
              r_good <= r_good + 4'd1;
              if ((r_good + 4'd1) >= VERIFY_LIM) begin
                r_state <= SYNC;
                r_sync  <= 1'b1;
              end
            end else begin
              r_miss <= 4'd0;
            end
          end
        end else if (w_comma && (r_state == SYNC)) begin
          if ((r_miss + 4'd1) >= LOSS_LIM) begin
            r_state <= HUNT;
            r_sync  <= 1'b0;
            r_miss  <= 4'd0;
            r_good  <= 4'd0;
          end else begin
            r_miss <= r_miss + 4'd1;
          end
        end
        // Timeout wins over any good/miss bookkeeping in the same cycle; the word still goes out.
        if (w_to_hit) begin
          r_state <= HUNT;
          r_sync  <= 1'b0;
          r_good  <= 4'd0;
          r_miss  <= 4'd0;
        end
      end
    end
  end

  assign o_Word       = r_word;
  assign o_Word_Valid = r_word_valid;
  assign o_Is_Comma   = r_is_comma;
  assign o_Sync       = r_sync;
  assign o_Realign    = r_realign;
  assign o_State      = r_state;

endmodule

// File: tb/tb_rx_word_align_ctrl.sv
// Scoreboard bench for rx_word_align_ctrl: a bench-side FIFO feeds bits, expected symbols are
// queued as stimulus is built and compared against symbols captured from the DUT.
module tb_rx_word_align_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       empty;
  logic       r_en;
  logic       bit_in;
  logic [9:0] word;
  logic       word_valid;
  logic       is_comma;
  logic       sync;
  logic       realign;
  logic [1:0] state;

  rx_word_align_ctrl #(.VERIFY_CNT(3), .LOSS_CNT(2), .TIMEOUT_WORDS(8)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_En(en), .i_Empty(empty), .o_R_en(r_en), .i_Bit(bit_in),
    .o_Word(word), .o_Word_Valid(word_valid), .o_Is_Comma(is_comma), .o_Sync(sync),
    .o_Realign(realign), .o_State(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] word;
    logic       comma;
    logic       realign;
    logic [1:0] state;
    logic       sync;
  } ev_t;

  localparam logic [9:0] K  = 10'h0FA;
  localparam logic [9:0] DA = 10'h2AA;
  localparam logic [9:0] DB = 10'h155;
  localparam logic [9:0] MS = 10'h28F;

  ev_t exp_q[$];
  ev_t cap_q[$];
  bit  fifo_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  always @(negedge clk)
    if (word_valid) cap_q.push_back('{word, is_comma, realign, state, sync});

  task automatic push_bits(input logic [9:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fifo_q.push_back(v[i]);
  endtask

  task automatic expect_ev(input logic [9:0] w, input logic c, input logic ra, input logic [1:0] st);
    exp_q.push_back('{w, c, ra, st, (st == 2'b10)});
  endtask

  // 3 garbage bits, then C D D C D D C: realign at the first comma, SYNC at the third.
  task automatic push_acquire();
    push_bits(10'b000, 3);
    push_bits(K, 10);  expect_ev(K, 1'b1, 1'b1, 2'b01);
    push_bits(DA, 10); expect_ev(DA, 1'b0, 1'b0, 2'b01);
    push_bits(DA, 10); expect_ev(DA, 1'b0, 1'b0, 2'b01);
    push_bits(K, 10);  expect_ev(K, 1'b1, 1'b0, 2'b01);
    push_bits(DA, 10); expect_ev(DA, 1'b0, 1'b0, 2'b01);
    push_bits(DA, 10); expect_ev(DA, 1'b0, 1'b0, 2'b01);
    push_bits(K, 10);  expect_ev(K, 1'b1, 1'b0, 2'b10);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; empty = 1'b1; bit_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    fifo_q.delete(); exp_q.delete(); cap_q.delete();
  endtask

  // Bench FIFO: read data appears the cycle after a sampled read enable.
  task automatic run_stream(input int gap_pct, input string tag);
    bit rd_prev = 1'b0;
    bit pend = 1'b0;
    int cyc = 0;
    while ((fifo_q.size() != 0 || rd_prev) && cyc < 20000) begin
      @(posedge clk); #1; cyc++;
      bit_in = rd_prev ? pend : 1'($urandom);
      en     = !($urandom_range(0, 99) < gap_pct);
      empty  = (fifo_q.size() == 0) || ($urandom_range(0, 99) < gap_pct);
      rd_prev = en && !empty;
      if (rd_prev) pend = fifo_q.pop_front();
    end
    if (cyc >= 20000) begin
      n_vec++; n_err++;
      $display("FAIL %s stream_timeout: got %0d bits left, want 0", tag, fifo_q.size());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; empty = 1'b0; bit_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (r_en !== 1'b0) begin n_err++; $display("FAIL reset r_en: got %b want 0", r_en); end
    n_vec++;
    if ({word, word_valid, is_comma, sync, realign, state} !== 16'h0) begin
      n_err++;
      $display("FAIL reset outputs: got word=%h v=%b c=%b s=%b r=%b st=%b want all 0",
               word, word_valid, is_comma, sync, realign, state);
    end
    #1 rst = 1'b0; empty = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (r_en !== 1'b0 || state !== 2'b00 || word_valid !== 1'b0 || sync !== 1'b0) begin
        n_err++;
        $display("FAIL reset idle cyc%0d: got r_en=%b st=%b v=%b s=%b want 0 00 0 0",
                 i, r_en, state, word_valid, sync);
      end
    end
    n_vec++;
    if (cap_q.size() != 0) begin n_err++; $display("FAIL reset words: got %0d want 0", cap_q.size()); end
    cap_q.delete();
  endtask

  task automatic test_acquire();
    do_reset();
    push_acquire();
    run_stream(0, "acquire");
    n_vec++;
    if (cap_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL acquire count: got %0d words want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_vec++;
      if (cap_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL acquire ev%0d: got w=%h c=%b r=%b st=%b s=%b want w=%h c=%b r=%b st=%b s=%b", i,
                 cap_q[i].word, cap_q[i].comma, cap_q[i].realign, cap_q[i].state, cap_q[i].sync,
                 exp_q[i].word, exp_q[i].comma, exp_q[i].realign, exp_q[i].state, exp_q[i].sync);
      end
    end
    n_vec++;
    if (sync !== 1'b1 || state !== 2'b10) begin
      n_err++; $display("FAIL acquire final: got s=%b st=%b want 1 10", sync, state);
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_loss_realign();
    do_reset();
    push_acquire();
    push_bits(DA, 10);         expect_ev(DA, 1'b0, 1'b0, 2'b10);
    push_bits(10'b1010, 4);
    push_bits(K, 10);          expect_ev(MS, 1'b0, 1'b0, 2'b10);
    push_bits(K, 10);          expect_ev(MS, 1'b0, 1'b0, 2'b10);
    push_bits(K, 10);          expect_ev(K, 1'b1, 1'b1, 2'b01);
    push_bits(DA, 10);         expect_ev(DA, 1'b0, 1'b0, 2'b01);
    push_bits(DB, 10);         expect_ev(DB, 1'b0, 1'b0, 2'b01);
    push_bits(K, 10);          expect_ev(K, 1'b1, 1'b0, 2'b01);
    run_stream(0, "loss");
    n_vec++;
    if (cap_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL loss count: got %0d words want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_vec++;
      if (cap_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL loss ev%0d: got w=%h c=%b r=%b st=%b s=%b want w=%h c=%b r=%b st=%b s=%b", i,
                 cap_q[i].word, cap_q[i].comma, cap_q[i].realign, cap_q[i].state, cap_q[i].sync,
                 exp_q[i].word, exp_q[i].comma, exp_q[i].realign, exp_q[i].state, exp_q[i].sync);
      end
    end
    n_vec++;
    if (state !== 2'b01) begin n_err++; $display("FAIL loss final: got st=%b want 01", state); end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_gaps();
    do_reset();
    push_acquire();
    push_bits(DB, 10); expect_ev(DB, 1'b0, 1'b0, 2'b10);
    push_bits(DA, 10); expect_ev(DA, 1'b0, 1'b0, 2'b10);
    push_bits(DB, 10); expect_ev(DB, 1'b0, 1'b0, 2'b10);
    push_bits(K, 10);  expect_ev(K, 1'b1, 1'b0, 2'b10);
    run_stream(40, "gaps");
    n_vec++;
    if (cap_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL gaps count: got %0d words want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_vec++;
      if (cap_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL gaps ev%0d: got w=%h c=%b r=%b st=%b s=%b want w=%h c=%b r=%b st=%b s=%b", i,
                 cap_q[i].word, cap_q[i].comma, cap_q[i].realign, cap_q[i].state, cap_q[i].sync,
                 exp_q[i].word, exp_q[i].comma, exp_q[i].realign, exp_q[i].state, exp_q[i].sync);
      end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_reset_pending();
    do_reset();
    push_acquire();
    run_stream(0, "rstpend");
    n_vec++;
    if (cap_q.size() != exp_q.size() || state !== 2'b10) begin
      n_err++;
      $display("FAIL rstpend pre: got %0d words st=%b want %0d words st=10", cap_q.size(), state, exp_q.size());
    end
    exp_q.delete(); cap_q.delete();
    @(posedge clk); #1 en = 1'b1; empty = 1'b0; bit_in = 1'b0;
    @(posedge clk); #1 rst = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    n_vec++;
    if (r_en !== 1'b0) begin n_err++; $display("FAIL rstpend r_en: got %b want 0", r_en); end
    @(posedge clk); #1 rst = 1'b0; empty = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({word, word_valid, is_comma, sync, realign, state} !== 16'h0) begin
      n_err++;
      $display("FAIL rstpend outputs: got word=%h v=%b c=%b s=%b r=%b st=%b want all 0",
               word, word_valid, is_comma, sync, realign, state);
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (cap_q.size() != 0 || state !== 2'b00) begin
      n_err++; $display("FAIL rstpend idle: got %0d words st=%b want 0 words st=00", cap_q.size(), state);
    end
    cap_q.delete();
    push_acquire();
    run_stream(0, "rstpend2");
    n_vec++;
    if (cap_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rstpend2 count: got %0d words want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_vec++;
      if (cap_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rstpend2 ev%0d: got w=%h c=%b r=%b st=%b want w=%h c=%b r=%b st=%b", i,
                 cap_q[i].word, cap_q[i].comma, cap_q[i].realign, cap_q[i].state,
                 exp_q[i].word, exp_q[i].comma, exp_q[i].realign, exp_q[i].state);
      end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_timeout();
    logic [1:0] last_st;
    do_reset();
    push_acquire();
`ifdef RX_ALIGN_TIMEOUT_EN
    last_st = 2'b00;
`else
    last_st = 2'b10;
`endif
    for (int i = 0; i < 8; i++) begin
      push_bits((i % 2 == 0) ? DA : DB, 10);
      expect_ev((i % 2 == 0) ? DA : DB, 1'b0, 1'b0, (i == 7) ? last_st : 2'b10);
    end
    run_stream(0, "timeout");
    n_vec++;
    if (cap_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL timeout count: got %0d words want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_vec++;
      if (cap_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL timeout ev%0d: got w=%h c=%b r=%b st=%b s=%b want w=%h c=%b r=%b st=%b s=%b", i,
                 cap_q[i].word, cap_q[i].comma, cap_q[i].realign, cap_q[i].state, cap_q[i].sync,
                 exp_q[i].word, exp_q[i].comma, exp_q[i].realign, exp_q[i].state, exp_q[i].sync);
      end
    end
    n_vec++;
    if (state !== last_st || sync !== (last_st == 2'b10)) begin
      n_err++; $display("FAIL timeout final: got st=%b s=%b want st=%b", state, sync, last_st);
    end
    exp_q.delete(); cap_q.delete();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; empty = 1'b1; bit_in = 1'b0;
    test_reset();
    test_acquire();
    test_loss_realign();
    test_gaps();
    test_reset_pending();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
